// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg -- shared types for the multi-mode counter.
//   cnt_mode_e  : boundary behaviour selector (WRAP, SAT, ONESHOT; 2'b11 is
//                 reserved and treated as WRAP by the counter)
//   cnt_state_e : counter run state (RUN, DONE)
//   cnt_clamps  : helper telling whether a mode clamps at the crossed bound
// ---------------------------------------------------------------------------
package cnt_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10,
        CNT_RSVD    = 2'b11
    } cnt_mode_e;

    typedef enum logic {
        CNT_RUN  = 1'b0,
        CNT_DONE = 1'b1
    } cnt_state_e;

    // SAT and ONESHOT both stop at the bound that was crossed; WRAP and the
    // reserved encoding jump to the opposite bound instead.
    function automatic logic cnt_clamps(input cnt_mode_e mode);
        logic clamp;
        case (mode)
            CNT_SAT, CNT_ONESHOT: clamp = 1'b1;
            default:              clamp = 1'b0;
        endcase
        return clamp;
    endfunction

endpackage

// File: rtl/cnt_next_calc.sv
// ---------------------------------------------------------------------------
// cnt_next_calc -- combinational next-value and boundary-event calculator.
//   cur       : current counter value
//   step      : unsigned step magnitude (0 means hold, never an event)
//   updown    : 1 = count up, 0 = count down
//   lo_bound  : inclusive lower limit
//   hi_bound  : inclusive upper limit
//   next_val  : cur +/- step truncated to WIDTH bits
//   bound_evt : carry/borrow, or result strictly outside the limits
// ---------------------------------------------------------------------------
module cnt_next_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] step,
    input  logic             updown,
    input  logic [WIDTH-1:0] lo_bound,
    input  logic [WIDTH-1:0] hi_bound,
    output logic [WIDTH-1:0] next_val,
    output logic             bound_evt
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Extended-width add/subtract so carry and borrow are visible in the MSB.
    always_comb begin
        sum_s     = {1'b0, cur} + {1'b0, step};
        diff_s    = {1'b0, cur} - {1'b0, step};
        next_val  = cur;
        bound_evt = 1'b0;
        if (step == {WIDTH{1'b0}}) begin
            next_val  = cur;
            bound_evt = 1'b0;
        end else if (updown) begin
            next_val  = sum_s[WIDTH-1:0];
            bound_evt = sum_s[WIDTH] | (sum_s[WIDTH-1:0] > hi_bound);
        end else begin
            next_val  = diff_s[WIDTH-1:0];
            bound_evt = diff_s[WIDTH] | (diff_s[WIDTH-1:0] < lo_bound);
        end
    end

endmodule

// File: rtl/cnt_multimode.sv
// ---------------------------------------------------------------------------
// cnt_multimode -- bounded up/down counter with WRAP / SAT / ONESHOT modes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : count enable (one step per edge)
//   load, in_data       : load value (not checked against the bounds)
//   updown              : 1 = up, 0 = down
//   step                : unsigned step magnitude
//   lo_bound, hi_bound  : inclusive limits
//   mode                : boundary behaviour (cnt_mode_e encoding)
//   clr                 : synchronous clear to lo_bound
//   out_data            : registered counter value
//   tc                  : one-cycle pulse after each boundary event
//   ovf                 : sticky boundary-event flag (cleared by clr)
//   done                : high while a ONESHOT run has finished
//   cfg_err             : combinational, lo_bound > hi_bound
// ---------------------------------------------------------------------------
module cnt_multimode
    import cnt_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo_bound,
    input  logic [WIDTH-1:0] hi_bound,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic [WIDTH-1:0] out_data,
    output logic             tc,
    output logic             ovf,
    output logic             done,
    output logic             cfg_err
);

    cnt_mode_e        mode_s;
    cnt_state_e       state_r;
    logic [WIDTH-1:0] cnt_r;
    logic             tc_r;
    logic             ovf_r;
    logic [WIDTH-1:0] next_s;
    logic             evt_s;
    logic [WIDTH-1:0] target_s;
    logic             count_ok_s;

    assign mode_s  = cnt_mode_e'(mode);
    assign cfg_err = (lo_bound > hi_bound);

    cnt_next_calc #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur       (cnt_r),
        .step      (step),
        .updown    (updown),
        .lo_bound  (lo_bound),
        .hi_bound  (hi_bound),
        .next_val  (next_s),
        .bound_evt (evt_s)
    );

    // Value taken on a boundary event: clamp to the crossed bound or wrap.
    always_comb begin
        target_s = lo_bound;
        if (cnt_clamps(mode_s)) begin
            target_s = updown ? hi_bound : lo_bound;
        end else begin
            target_s = updown ? lo_bound : hi_bound;
        end
    end

    // Counting only happens in RUN with a consistent bound configuration.
    assign count_ok_s = en & (state_r == CNT_RUN) & ~cfg_err;

    // Counter state machine: clr > load > count > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= RESET_VAL;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            state_r <= CNT_RUN;
        end else if (clr) begin
            cnt_r   <= lo_bound;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            state_r <= CNT_RUN;
        end else if (load) begin
            cnt_r   <= in_data;
            tc_r    <= 1'b0;
            state_r <= CNT_RUN;
        end else if (count_ok_s) begin
            if (evt_s) begin
                cnt_r <= target_s;
                tc_r  <= 1'b1;
                ovf_r <= 1'b1;
                if (mode_s == CNT_ONESHOT) begin
                    state_r <= CNT_DONE;
                end else begin
                    state_r <= state_r;
                end
            end else begin
                // step == 0 lands here with next_s equal to the held value.
                cnt_r <= next_s;
                tc_r  <= 1'b0;
            end
        end else begin
            tc_r <= 1'b0;
        end
    end

    assign out_data = cnt_r;
    assign tc       = tc_r;
    assign ovf      = ovf_r;
    assign done     = (state_r == CNT_DONE);

endmodule

// File: tb/tb_cnt_multimode.sv
// ---------------------------------------------------------------------------
// tb_cnt_multimode -- self-checking bench for cnt_multimode (WIDTH = 8).
// Directed table of per-cycle vectors, an asynchronous-reset sequence and a
// randomized phase compared against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_cnt_multimode;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, load, updown, clr;
    logic [W-1:0] in_data, step, lo_bound, hi_bound;
    logic [1:0]   mode;
    logic [W-1:0] out_data;
    logic         tc, ovf, done, cfg_err;

    int n_chk  = 0;
    int n_pass = 0;

    cnt_multimode #(.WIDTH(W), .RESET_VAL(8'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .updown   (updown),
        .in_data  (in_data),
        .step     (step),
        .lo_bound (lo_bound),
        .hi_bound (hi_bound),
        .mode     (mode),
        .clr      (clr),
        .out_data (out_data),
        .tc       (tc),
        .ovf      (ovf),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int e_out, input int e_tc,
                           input int e_ovf, input int e_done, input int e_cfg);
        chk({tag, " out"},  int'(out_data), e_out);
        chk({tag, " tc"},   int'(tc),       e_tc);
        chk({tag, " ovf"},  int'(ovf),      e_ovf);
        chk({tag, " done"}, int'(done),     e_done);
        chk({tag, " cfg"},  int'(cfg_err),  e_cfg);
    endtask

    typedef struct {
        int c, l, e, ud, in_d, st, lo, hi, md;
        int e_out, e_tc, e_ovf, e_done, e_cfg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int c, int l, int e, int ud, int in_d, int st,
                                int lo, int hi, int md, int e_out, int e_tc,
                                int e_ovf, int e_done, int e_cfg);
        vec_t v;
        v.c = c; v.l = l; v.e = e; v.ud = ud; v.in_d = in_d; v.st = st;
        v.lo = lo; v.hi = hi; v.md = md; v.e_out = e_out; v.e_tc = e_tc;
        v.e_ovf = e_ovf; v.e_done = e_done; v.e_cfg = e_cfg;
        return v;
    endfunction

    task automatic drive(input int c, input int l, input int e, input int ud,
                         input int in_d, input int st, input int lo,
                         input int hi, input int md);
        clr      = c[0];
        load     = l[0];
        en       = e[0];
        updown   = ud[0];
        in_data  = in_d[7:0];
        step     = st[7:0];
        lo_bound = lo[7:0];
        hi_bound = hi[7:0];
        mode     = md[1:0];
    endtask

    // Reference model state
    int m_out, m_tc, m_ovf, m_done;

    task automatic model_step(input int c, input int l, input int e, input int ud,
                              input int in_d, input int st, input int lo,
                              input int hi, input int md);
        int  n;
        bit  ev;
        if (c != 0) begin
            m_out = lo; m_ovf = 0; m_tc = 0; m_done = 0;
        end else if (l != 0) begin
            m_out = in_d; m_tc = 0; m_done = 0;
        end else if (e != 0 && m_done == 0 && lo <= hi && st != 0) begin
            n  = (ud != 0) ? m_out + st : m_out - st;
            ev = (ud != 0) ? (n > hi) : (n < lo);
            if (ev) begin
                if (md == 1 || md == 2) m_out = (ud != 0) ? hi : lo;
                else                    m_out = (ud != 0) ? lo : hi;
                m_tc = 1; m_ovf = 1;
                if (md == 2) m_done = 1;
            end else begin
                m_out = n; m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    initial begin
        // Directed per-cycle vectors:
        //          clr ld en ud  in st  lo  hi md | out tc ovf done cfg
        vecs.push_back(mk(0,1,0,1, 18, 3, 10, 20,0,  18,0,0,0,0)); // load
        vecs.push_back(mk(0,0,1,1,  0, 3, 10, 20,0,  10,1,1,0,0)); // wrap up
        vecs.push_back(mk(0,0,0,1,  0, 3, 10, 20,0,  10,0,1,0,0)); // tc drops
        vecs.push_back(mk(1,0,0,1,  0, 3,  5, 20,0,   5,0,0,0,0)); // clr
        vecs.push_back(mk(0,1,0,0,  7, 4,  5, 20,1,   7,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,  0, 4,  5, 20,1,   5,1,1,0,0)); // sat down
        vecs.push_back(mk(0,0,1,0,  0, 4,  5, 20,1,   5,1,1,0,0));
        vecs.push_back(mk(0,0,1,0,  0, 4,  5, 20,1,   5,1,1,0,0));
        vecs.push_back(mk(0,1,0,0,  9, 4,  5, 20,1,   9,0,1,0,0)); // ovf kept
        vecs.push_back(mk(0,0,1,0,  0, 4,  5, 20,1,   5,0,1,0,0)); // exact lo
        vecs.push_back(mk(0,1,0,1, 16, 4,  5, 20,1,  16,0,1,0,0));
        vecs.push_back(mk(0,0,1,1,  0, 4,  5, 20,1,  20,0,1,0,0)); // exact hi
        vecs.push_back(mk(0,1,0,1,250,10,  0,255,2, 250,0,1,0,0));
        vecs.push_back(mk(0,0,1,1,  0,10,  0,255,2, 255,1,1,1,0)); // oneshot
        vecs.push_back(mk(0,0,1,1,  0,10,  0,255,2, 255,0,1,1,0)); // en ignored
        vecs.push_back(mk(0,0,1,1,  0,10,  0,255,0, 255,0,1,1,0)); // mode chg
        vecs.push_back(mk(0,1,1,1,  0,10,  0,255,0,   0,0,1,0,0)); // load wins
        vecs.push_back(mk(0,0,1,1,  0,10,  0,255,0,  10,0,1,0,0)); // resumes
        vecs.push_back(mk(1,1,1,1, 99,10,  3,255,0,   3,0,0,0,0)); // clr prio
        vecs.push_back(mk(0,1,0,1, 99,10,  3,255,0,  99,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,  0, 1, 50, 40,0,  99,0,0,0,1)); // cfg_err
        vecs.push_back(mk(0,0,1,1,  0, 0,  0,255,0,  99,0,0,0,0)); // step 0
        vecs.push_back(mk(0,0,1,1,  0, 5,  0,100,3,   0,1,1,0,0)); // rsvd wrap
        vecs.push_back(mk(0,0,1,0,  0, 1,  0,100,3, 100,1,1,0,0)); // borrow
        vecs.push_back(mk(0,0,1,1,  0, 5,  0,100,1, 100,1,1,0,0)); // sat hi

        rst_n = 1'b0;
        drive(0, 0, 0, 1, 0, 1, 0, 255, 0);
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].ud, vecs[i].in_d,
                  vecs[i].st, vecs[i].lo, vecs[i].hi, vecs[i].md);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_tc,
                    vecs[i].e_ovf, vecs[i].e_done, vecs[i].e_cfg);
        end

        // Asynchronous reset while in DONE with ovf set.
        drive(0, 1, 0, 1, 250, 10, 0, 255, 2);
        @(posedge clk); #1;
        drive(0, 0, 1, 1, 0, 10, 0, 255, 2);
        @(posedge clk); #1;
        chk("pre-reset done", int'(done), 1);
        #3 rst_n = 1'b0;
        #1;
        chk_all("async rst", 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        drive(0, 0, 1, 1, 0, 10, 0, 255, 0);
        @(posedge clk); #1;
        chk_all("post rst", 10, 0, 0, 0, 0);

        // Randomized phase against the reference model.
        m_out = 10; m_tc = 0; m_ovf = 0; m_done = 0;
        begin
            int r_lo, r_hi, r_md, r_st;
            r_lo = 0; r_hi = 255; r_md = 0; r_st = 5;
            for (int i = 0; i < 400; i++) begin
                int r_c, r_l, r_e, r_ud, r_in;
                if ($urandom_range(0, 7) == 0) begin
                    r_lo = $urandom_range(0, 120);
                    if ($urandom_range(0, 11) == 0) r_hi = $urandom_range(0, r_lo);
                    else                            r_hi = $urandom_range(r_lo, 255);
                    r_md = $urandom_range(0, 3);
                end
                if ($urandom_range(0, 5) == 0)
                    r_st = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
                r_c  = ($urandom_range(0, 19) == 0) ? 1 : 0;
                r_l  = ($urandom_range(0, 11) == 0) ? 1 : 0;
                r_e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                r_ud = $urandom_range(0, 1);
                r_in = $urandom_range(0, 255);
                drive(r_c, r_l, r_e, r_ud, r_in, r_st, r_lo, r_hi, r_md);
                model_step(r_c, r_l, r_e, r_ud, r_in, r_st, r_lo, r_hi, r_md);
                @(posedge clk); #1;
                chk_all($sformatf("rand%0d", i), m_out, m_tc, m_ovf, m_done,
                        (r_lo > r_hi) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
